// File: rtl/spi_bus_arbiter_if.sv
// Bundle of requester handshake signals and the shared SPI pins for spi_bus_arbiter.
// master: the arbiter side; slave: requesters plus the SPI device side.
interface spi_bus_arbiter_if #(
  parameter int REG_WID = 8,
  parameter int NUM     = $clog2(REG_WID),
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*REG_WID-1:0]   req_data;
  logic [NUM_REQ*(NUM+1)-1:0]   req_size;
  logic [NUM_REQ*2-1:0]         req_mode;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [REG_WID-1:0]           rx_data;
  logic                         busy;
  logic                         spi_clk;
  logic                         mosi;
  logic                         miso;
  logic [NUM_REQ-1:0]           cs_n;

  modport master (
    input  req, req_data, req_size, req_mode, miso,
    output grant, done, rx_data, busy, spi_clk, mosi, cs_n
  );

  modport slave (
    output req, req_data, req_size, req_mode, miso,
    input  grant, done, rx_data, busy, spi_clk, mosi, cs_n
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin SPI master shared by NUM_REQ requesters; LSB-first, per-transaction cpol/cphase/size.
// Define SPI_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins arbitration.
module spi_bus_arbiter #(
  parameter int REG_WID = 8,
  parameter int NUM     = $clog2(REG_WID),
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_bus_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int SZ_W  = NUM + 1;
  localparam int HC_W  = NUM + 2;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [HC_W-1:0]    half_cnt_reg, half_cnt_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [REG_WID-1:0] tx_reg, tx_next;
  logic [REG_WID-1:0] rx_reg, rx_next;
  logic [REG_WID-1:0] rx_data_reg, rx_data_next;
  logic [SZ_W-1:0]    size_reg, size_next;
  logic               cpol_reg, cpol_next;
  logic               cpha_reg, cpha_next;
  logic               spi_clk_reg, spi_clk_next;
  logic               mosi_reg, mosi_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] cs_n_reg, cs_n_next;

  logic [REG_WID-1:0] data_arr [NUM_REQ];
  logic [SZ_W-1:0]    size_arr [NUM_REQ];
  logic [1:0]         mode_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*REG_WID +: REG_WID];
      assign size_arr[gi] = bus.req_size[gi*SZ_W +: SZ_W];
      assign mode_arr[gi] = bus.req_mode[2*gi +: 2];
    end
  endgenerate

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [SZ_W-1:0]  win_size;

`ifdef SPI_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[PTR_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(k);
      end
    end
  end
`else
  logic [PTR_W:0] rr_idx;

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (rr_idx >= (PTR_W+1)'(NUM_REQ))
        rr_idx = rr_idx - (PTR_W+1)'(NUM_REQ);
      if (!win_found && bus.req[rr_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_idx[PTR_W-1:0];
      end
    end
  end
`endif

  assign win_size = (size_arr[win_idx] > SZ_W'(REG_WID)) ? SZ_W'(REG_WID) : size_arr[win_idx];

  logic            div_last;
  logic [HC_W-1:0] half_last;
  logic [SZ_W-1:0] rx_shamt;
  logic            lead_edge;
  logic            trail_edge;

  assign div_last  = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign half_last = {size_reg, 1'b0} - HC_W'(1);
  assign rx_shamt  = SZ_W'(REG_WID) - size_reg;

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    half_cnt_next = half_cnt_reg;
    ptr_next      = ptr_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    rx_data_next  = rx_data_reg;
    size_next     = size_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;
    spi_clk_next  = spi_clk_reg;
    mosi_next     = mosi_reg;
    grant_next    = grant_reg;
    done_next     = '0;
    cs_n_next     = cs_n_reg;
    lead_edge     = 1'b0;
    trail_edge    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          ptr_next     = win_idx;
          tx_next      = data_arr[win_idx];
          rx_next      = '0;
          size_next    = win_size;
          cpol_next    = mode_arr[win_idx][1];
          cpha_next    = mode_arr[win_idx][0];
          spi_clk_next = mode_arr[win_idx][1];
          mosi_next    = mode_arr[win_idx][0] ? 1'b0 : data_arr[win_idx][0];
          grant_next   = NUM_REQ'(1) << win_idx;
          cs_n_next    = ~(NUM_REQ'(1) << win_idx);
          div_cnt_next = '0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_cnt_next  = '0;
          half_cnt_next = '0;
          if (size_reg == '0) begin
            state_next = HOLD;
          end else begin
            state_next   = XFER;
            spi_clk_next = ~spi_clk_reg;
            lead_edge    = 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      XFER: begin
        if (div_last) begin
          div_cnt_next = '0;
          if (half_cnt_reg == half_last) begin
            state_next = HOLD;
          end else begin
            // Even half periods open a bit (leading edge), odd ones close it (trailing edge).
            half_cnt_next = half_cnt_reg + HC_W'(1);
            spi_clk_next  = ~spi_clk_reg;
            lead_edge     = half_cnt_reg[0];
            trail_edge    = ~half_cnt_reg[0];
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          div_cnt_next = '0;
          cs_n_next    = '1;
          grant_next   = '0;
          done_next    = grant_reg;
          rx_data_next = rx_reg >> rx_shamt;
          mosi_next    = 1'b0;
          state_next   = GAP;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_last) begin
          div_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if ((lead_edge && !cpha_reg) || (trail_edge && cpha_reg))
      rx_next = {bus.miso, rx_reg[REG_WID-1:1]};
    if (lead_edge && cpha_reg) begin
      mosi_next = tx_reg[0];
      tx_next   = tx_reg >> 1;
    end
    if (trail_edge && !cpha_reg) begin
      mosi_next = tx_reg[1];
      tx_next   = tx_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      half_cnt_reg <= '0;
      ptr_reg      <= PTR_W'(NUM_REQ - 1);
      tx_reg       <= '0;
      rx_reg       <= '0;
      rx_data_reg  <= '0;
      size_reg     <= '0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      spi_clk_reg  <= 1'b0;
      mosi_reg     <= 1'b0;
      grant_reg    <= '0;
      done_reg     <= '0;
      cs_n_reg     <= '1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      half_cnt_reg <= half_cnt_next;
      ptr_reg      <= ptr_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      rx_data_reg  <= rx_data_next;
      size_reg     <= size_next;
      cpol_reg     <= cpol_next;
      cpha_reg     <= cpha_next;
      spi_clk_reg  <= spi_clk_next;
      mosi_reg     <= mosi_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      cs_n_reg     <= cs_n_next;
    end
  end

  assign bus.grant   = grant_reg;
  assign bus.done    = done_reg;
  assign bus.rx_data = rx_data_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.spi_clk = spi_clk_reg;
  assign bus.mosi    = mosi_reg;
  assign bus.cs_n    = cs_n_reg;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: scoreboard of expected (owner, rx_data) checked at each done pulse.
module tb_spi_bus_arbiter;
  localparam int REG_WID = 8;
  localparam int NUM     = 3;
  localparam int NUM_REQ = 4;
  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.REG_WID(REG_WID), .NUM(NUM), .NUM_REQ(NUM_REQ)) bus ();

  spi_bus_arbiter #(
    .REG_WID(REG_WID), .NUM(NUM), .NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         idx;
    logic [7:0] rx;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // miso source: 0 loopback from mosi, 1 model slave, 2 constant one
  int         miso_sel = 0;
  logic       s_miso   = 1'b0;
  logic [1:0] s_mode   = 2'b00;
  logic [7:0] s_load   = 8'h00;
  logic [7:0] s_sh     = 8'h00;
  logic       s_prev_cs  = 1'b0;
  logic       s_prev_clk = 1'b0;
  logic       cs_low;

  assign cs_low   = ~&bus.cs_n;
  assign bus.miso = (miso_sel == 0) ? bus.mosi : (miso_sel == 1) ? s_miso : 1'b1;

  // LSB-first slave: cphase 0 presents on select and shifts on trailing edges, cphase 1 presents on leading edges.
  always @(negedge clk) begin
    if (cs_low && !s_prev_cs) begin
      s_sh = s_load;
      if (!s_mode[0]) s_miso = s_sh[0];
    end else if (cs_low && (bus.spi_clk !== s_prev_clk)) begin
      if (bus.spi_clk != s_mode[1]) begin
        if (s_mode[0]) begin
          s_miso = s_sh[0];
          s_sh   = s_sh >> 1;
        end
      end else if (!s_mode[0]) begin
        s_sh   = s_sh >> 1;
        s_miso = s_sh[0];
      end
    end
    s_prev_cs  = cs_low;
    s_prev_clk = bus.spi_clk;
  end

  logic       prev_cs_low = 1'b0;
  logic       prev_sclk   = 1'b0;
  logic       prev_busy   = 1'b0;
  int         cs_low_cnt  = 0;
  int         toggles     = 0;
  int         busy_cnt    = 0;
  logic [7:0] mosi_word   = 8'h00;
  int         last_cs_low  = -1;
  int         last_toggles = -1;
  int         last_busy    = -1;
  logic [7:0] last_mosi    = 8'h00;
  int         done_cnt     = 0;

  always @(negedge clk) begin
    if (cs_low) begin
      if (!prev_cs_low) begin
        cs_low_cnt = 1;
        toggles    = 0;
        mosi_word  = 8'h00;
      end else begin
        cs_low_cnt++;
        if (bus.spi_clk !== prev_sclk) toggles++;
        if (bus.spi_clk && !prev_sclk) mosi_word = {bus.mosi, mosi_word[7:1]};
      end
    end
    if (bus.busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
    else if (prev_busy) last_busy = busy_cnt;
    if (bus.done !== '0) begin
      last_cs_low  = cs_low_cnt;
      last_toggles = toggles;
      last_mosi    = mosi_word;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_owner", 32'(bus.done), 32'd1 << mon_e.idx);
        check("rx_data", 32'(bus.rx_data), 32'(mon_e.rx));
        $display("txn owner=%0d done=%b rx_data=%02h expected=%02h cs_low=%0d toggles=%0d",
                 mon_e.idx, bus.done, bus.rx_data, mon_e.rx, cs_low_cnt, toggles);
      end
    end
    prev_cs_low = cs_low;
    prev_sclk   = bus.spi_clk;
    prev_busy   = bus.busy;
  end

  task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] sz, input logic [1:0] m);
    bus.req_data[i*REG_WID +: REG_WID] = d;
    bus.req_size[i*(NUM+1) +: NUM+1]   = sz;
    bus.req_mode[2*i +: 2]             = m;
  endtask

  task automatic push_exp(input int i, input logic [7:0] rx);
    exp_t e;
    e.idx = i;
    e.rx  = rx;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #2;
      if (done_cnt >= target) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL wait_done timeout observed=%0d expected=%0d", done_cnt, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #2;
      if (!bus.busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL wait_idle timeout observed=%0b expected=0", bus.busy);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      #2;
      if (bus.grant[i]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL wait_grant timeout observed=%b expected_bit=%0d", bus.grant, i);
    end
  endtask

  int         n_done = 0;
  logic [7:0] rr_data [4];
  int         rr_order [5];

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_size = '0;
    bus.req_mode = '0;
    rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h44;
`ifdef SPI_ARB_FIXED_PRIORITY_EN
    rr_order[0] = 0; rr_order[1] = 0; rr_order[2] = 0; rr_order[3] = 0; rr_order[4] = 0;
`else
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 2; rr_order[3] = 3; rr_order[4] = 0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_spi_clk", 32'(bus.spi_clk), 32'd0);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_cs_n", 32'(bus.cs_n), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 loopback, A5, size 8
    miso_sel = 0;
    set_req(0, 8'hA5, 4'd8, 2'b00);
    push_exp(0, 8'hA5);
    bus.req[0] = 1'b1;
    n_done++;
    wait_done(n_done, 300);
    bus.req[0] = 1'b0;
    check("m0_cs_low_cycles", 32'(last_cs_low), 32'd36);
    check("m0_sclk_edges", 32'(last_toggles), 32'd16);
    check("m0_mosi_bits", 32'(last_mosi), 32'hA5);
    wait_idle(50);
    check("m0_busy_cycles", 32'(last_busy), 32'd38);
    check("m0_sclk_idle", 32'(bus.spi_clk), 32'd0);

    // All four modes against the model slave
    miso_sel = 1;
    s_load   = 8'hC3;
    for (int m = 0; m < 4; m++) begin
      s_mode = 2'(m);
      set_req(0, 8'h3C, 4'd8, 2'(m));
      push_exp(0, 8'hC3);
      bus.req[0] = 1'b1;
      n_done++;
      wait_done(n_done, 300);
      bus.req[0] = 1'b0;
      check("mode_sclk_edges", 32'(last_toggles), 32'd16);
      wait_idle(50);
      check("mode_sclk_idle", 32'(bus.spi_clk), 32'(s_mode[1]));
    end

    // Fresh reset, then all four requesting continuously
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    miso_sel = 0;
    for (int i = 0; i < 4; i++) set_req(i, rr_data[i], 4'd8, 2'b00);
    for (int k = 0; k < 5; k++) push_exp(rr_order[k], rr_data[rr_order[k]]);
    bus.req = 4'b1111;
    n_done += 5;
    wait_done(n_done, 1500);
    bus.req = 4'b0000;
    wait_idle(50);
    check("rr_queue_drained", 32'(sb_q.size()), 32'd0);

    // Size 0 then size 12 (clamped) on requester 2
    set_req(2, 8'h77, 4'd0, 2'b00);
    push_exp(2, 8'h00);
    bus.req[2] = 1'b1;
    n_done++;
    wait_done(n_done, 100);
    bus.req[2] = 1'b0;
    check("sz0_cs_low_cycles", 32'(last_cs_low), 32'd4);
    check("sz0_sclk_edges", 32'(last_toggles), 32'd0);
    wait_idle(50);
    set_req(2, 8'h5A, 4'd12, 2'b00);
    push_exp(2, 8'h5A);
    bus.req[2] = 1'b1;
    n_done++;
    wait_done(n_done, 300);
    bus.req[2] = 1'b0;
    check("sz12_sclk_edges", 32'(last_toggles), 32'd16);
    check("sz12_cs_low_cycles", 32'(last_cs_low), 32'd36);
    wait_idle(50);

    // Size 5 with miso stuck high: valid bits right-aligned
    miso_sel = 2;
    set_req(1, 8'h00, 4'd5, 2'b00);
    push_exp(1, 8'h1F);
    bus.req[1] = 1'b1;
    n_done++;
    wait_done(n_done, 300);
    bus.req[1] = 1'b0;
    check("sz5_sclk_edges", 32'(last_toggles), 32'd10);
    wait_idle(50);

    // Reset in the middle of requester 1's transfer, requester 3 pending
    miso_sel = 0;
    set_req(1, 8'hE7, 4'd8, 2'b10);
    set_req(3, 8'h96, 4'd8, 2'b00);
    push_exp(1, 8'hE7);
    bus.req[1] = 1'b1;
    wait_grant(1, 50);
    repeat (10) @(posedge clk);
    bus.req[3] = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check("abort_cs_n", 32'(bus.cs_n), 32'hF);
    check("abort_spi_clk", 32'(bus.spi_clk), 32'd0);
    check("abort_grant", 32'(bus.grant), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    void'(sb_q.pop_back());
    bus.req[1] = 1'b0;
    push_exp(3, 8'h96);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_done++;
    wait_done(n_done, 300);
    bus.req[3] = 1'b0;
    check("post_rst_cs_low_cycles", 32'(last_cs_low), 32'd36);
    wait_idle(50);
    repeat (10) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'(n_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
